// File: rtl/tcam_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// tcam_pkg: lookup-host state encoding, result field layout and default TCAM register map.
// Rev 1.0
package tcam_pkg;

    localparam logic [31:0] DefaultKeyAddr    = 32'h0000_0000;
    localparam logic [31:0] DefaultResultAddr = 32'h0000_0004;

    localparam int HitBit   = 31;
    localparam int IndexW   = 6;
    localparam int TimeoutW = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_RSP = 3'd2,
        RD_REQ = 3'd3,
        RD_RSP = 3'd4,
        RESP   = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/tlul_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// tlul_pkg: TL-UL channel structures and opcodes shared by hosts and devices.
// Rev 1.0
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage
`default_nettype wire

// File: rtl/tcam_lookup_host.sv
`timescale 1ns/1ps
`default_nettype none
// tcam_lookup_host: writes a search key to the TCAM over TL-UL, reads back the result register.
// Rev 1.0
module tcam_lookup_host
    import tcam_pkg::*;
#(
    parameter logic [31:0] KeyAddr       = DefaultKeyAddr,
    parameter logic [31:0] ResultAddr    = DefaultResultAddr,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [31:0]         req_key_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic                rsp_hit_o,
    output logic [IndexW-1:0]   rsp_index_o,
    output logic                rsp_err_o,
    output tlul_pkg::tl_h2d_t   tl_h_o,
    input  tlul_pkg::tl_d2h_t   tl_h_i
);

    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TimeoutCycles - 1);

    state_e              state_q, state_d;
    logic [31:0]         key_q, key_d;
    logic [TimeoutW-1:0] cnt_q, cnt_d;
    logic                hit_q, hit_d;
    logic [IndexW-1:0]   index_q, index_d;
    logic                err_q, err_d;

    logic w_timeout;
    logic w_unused_tl;

    assign w_timeout   = (cnt_q == TimeoutLast);
    assign w_unused_tl = ^{tl_h_i.d_opcode, tl_h_i.d_param, tl_h_i.d_size, tl_h_i.d_source,
                           tl_h_i.d_sink, tl_h_i.d_data[HitBit-1:IndexW]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            index_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            index_q <= index_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        index_d = index_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    key_d   = req_key_i;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (tl_h_i.a_ready) begin
                    cnt_d   = '0;
                    state_d = WR_RSP;
                end
            end
            WR_RSP: begin
                // A response in the timeout cycle still wins over the timeout.
                if (tl_h_i.d_valid) begin
                    if (tl_h_i.d_error) begin
                        hit_d   = 1'b0;
                        index_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = RD_REQ;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (w_timeout) begin
                        hit_d   = 1'b0;
                        index_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RD_REQ: begin
                if (tl_h_i.a_ready) begin
                    cnt_d   = '0;
                    state_d = RD_RSP;
                end
            end
            RD_RSP: begin
                if (tl_h_i.d_valid) begin
                    hit_d   = tl_h_i.d_data[HitBit] & ~tl_h_i.d_error;
                    index_d = tl_h_i.d_error ? '0 : tl_h_i.d_data[IndexW-1:0];
                    err_d   = tl_h_i.d_error;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (w_timeout) begin
                        hit_d   = 1'b0;
                        index_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request fields depend only on state and the latched key, so they hold until a_ready.
    always_comb begin
        tl_h_o          = '0;
        tl_h_o.a_size   = 2'd2;
        tl_h_o.a_mask   = 4'hF;
        tl_h_o.a_source = 8'd0;
        case (state_q)
            WR_REQ: begin
                tl_h_o.a_valid   = 1'b1;
                tl_h_o.a_opcode  = tlul_pkg::PutFullData;
                tl_h_o.a_address = KeyAddr;
                tl_h_o.a_data    = key_q;
            end
            RD_REQ: begin
                tl_h_o.a_valid   = 1'b1;
                tl_h_o.a_opcode  = tlul_pkg::Get;
                tl_h_o.a_address = ResultAddr;
            end
            WR_RSP, RD_RSP: begin
                tl_h_o.d_ready = 1'b1;
            end
            default: begin
                tl_h_o.a_valid = 1'b0;
            end
        endcase
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_hit_o   = hit_q;
    assign rsp_index_o = index_q;
    assign rsp_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tcam_lookup_host.sv
`timescale 1ns/1ps
`default_nettype none
// tb_tcam_lookup_host: randomized lookups against a transaction-level model of the TL-UL host.
// Rev 1.0
module tb_tcam_lookup_host;
    import tlul_pkg::*;

    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
    logic [31:0] req_key_i;
    logic        rsp_hit_o, rsp_err_o;
    logic [5:0]  rsp_index_o;
    tl_h2d_t     tl_h;
    tl_d2h_t     tl_d;

    tcam_lookup_host #(
        .KeyAddr       (32'h0000_0000),
        .ResultAddr    (32'h0000_0004),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_key_i   (req_key_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_hit_o   (rsp_hit_o),
        .rsp_index_o (rsp_index_o),
        .rsp_err_o   (rsp_err_o),
        .tl_h_o      (tl_h),
        .tl_h_i      (tl_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] key;
        bit          wr_err, drop_wr, rd_err, drop_rd;
        logic [31:0] rd_data;
        int          dly;
    } cfg_t;

    cfg_t cfg_q[$];
    cfg_t cur_cfg;

    int checks = 0, errors = 0;

    // Transaction-level model state
    bit          m_busy, m_a_pend, m_is_read, m_rsp;
    int          m_wait;
    logic [31:0] m_key;
    logic        m_hit, m_err;
    logic [5:0]  m_idx;
    int cyc = 0, n_acc = 0, n_done = 0, n_put = 0, n_get = 0;
    int t_req = 0, t_wr = 0, t_rsp = -1;
    logic       last_hit, last_err;
    logic [5:0] last_idx;
    int last_lat, last_wr_lat, last_gets, last_puts;

    // Device-side controls
    int ar_hold = 0, rr_hold = 0;
    bit rand_ar = 0, rand_rr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_a_pend = 0; m_is_read = 0; m_rsp = 0; m_wait = 0;
    endtask

    // Compare process: sampled 1 time unit before each rising edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (!rst_ni) begin
                model_reset();
                chk("rst_a_valid", tl_h.a_valid, 0);
                chk("rst_d_ready", tl_h.d_ready, 0);
                chk("rst_rsp_valid", rsp_valid_o, 0);
                chk("rst_rsp_fields", {rsp_hit_o, rsp_index_o, rsp_err_o}, 0);
                continue;
            end
            chk("req_ready", req_ready_o, !m_busy);
            chk("a_valid", tl_h.a_valid, m_a_pend);
            chk("d_ready", tl_h.d_ready, m_wait > 0);
            chk("rsp_valid", rsp_valid_o, m_rsp);
            if (m_a_pend && tl_h.a_valid) begin
                chk("a_opcode", tl_h.a_opcode, m_is_read ? Get : PutFullData);
                chk("a_address", tl_h.a_address, m_is_read ? 32'h4 : 32'h0);
                if (!m_is_read) chk("a_data", tl_h.a_data, m_key);
                chk("a_mask", tl_h.a_mask, 4'hF);
                chk("a_size", tl_h.a_size, 2);
                chk("a_source", tl_h.a_source, 0);
            end
            if (m_rsp && rsp_valid_o) begin
                chk("rsp_hit", rsp_hit_o, m_hit);
                chk("rsp_index", rsp_index_o, m_idx);
                chk("rsp_err", rsp_err_o, m_err);
                if (t_rsp < 0) t_rsp = cyc;
            end
            if (!m_busy) begin
                if (req_valid_i) begin
                    m_busy = 1; m_a_pend = 1; m_is_read = 0; m_key = req_key_i;
                    if (cfg_q.size() > 0) cur_cfg = cfg_q.pop_front();
                    t_req = cyc; t_rsp = -1; n_put = 0; n_get = 0; n_acc++;
                end
            end else if (m_a_pend) begin
                if (tl_d.a_ready) begin
                    m_a_pend = 0; m_wait = TO;
                    if (m_is_read) n_get++;
                    else begin n_put++; t_wr = cyc; end
                end
            end else if (m_wait > 0) begin
                if (tl_d.d_valid) begin
                    m_wait = 0;
                    if (!m_is_read && !tl_d.d_error) begin
                        m_a_pend = 1; m_is_read = 1;
                    end else begin
                        m_rsp = 1;
                        m_err = tl_d.d_error;
                        m_hit = m_is_read && !tl_d.d_error && tl_d.d_data[31];
                        m_idx = (m_is_read && !tl_d.d_error) ? tl_d.d_data[5:0] : 6'd0;
                    end
                end else begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_rsp = 1; m_err = 1; m_hit = 0; m_idx = 0;
                    end
                end
            end else if (m_rsp && rsp_ready_i) begin
                m_rsp = 0; m_busy = 0; n_done++;
                last_hit = m_hit; last_idx = m_idx; last_err = m_err;
                last_lat = t_rsp - t_req; last_wr_lat = t_rsp - t_wr;
                last_gets = n_get; last_puts = n_put;
            end
        end
    end

    // TCAM device: drives the d2h channel on falling edges.
    initial begin
        bit p_av, p_ar, p_rd, p_dv, p_dr, pend, perr;
        logic [31:0] pdata;
        int pdly;
        tl_d = '0;
        cur_cfg.key = 0; cur_cfg.wr_err = 0; cur_cfg.drop_wr = 0;
        cur_cfg.rd_err = 0; cur_cfg.drop_rd = 0; cur_cfg.rd_data = 0; cur_cfg.dly = 0;
        p_av = 0; p_ar = 0; p_rd = 0; p_dv = 0; p_dr = 0; pend = 0; perr = 0; pdata = 0; pdly = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                tl_d = '0;
                p_av = 0; p_ar = 0; p_dv = 0; p_dr = 0; pend = 0;
                continue;
            end
            if (p_av && p_ar) begin
                if (p_rd && !cur_cfg.drop_rd) begin
                    pend = 1; pdata = cur_cfg.rd_data; perr = cur_cfg.rd_err; pdly = cur_cfg.dly;
                end else if (!p_rd && !cur_cfg.drop_wr) begin
                    pend = 1; pdata = 0; perr = cur_cfg.wr_err; pdly = cur_cfg.dly;
                end
            end
            if (p_dv && p_dr) pend = 0;
            tl_d.d_valid = 0; tl_d.d_error = 0; tl_d.d_data = 0; tl_d.d_opcode = AccessAck;
            if (pend) begin
                if (pdly > 0) pdly--;
                else begin
                    tl_d.d_valid = 1; tl_d.d_data = pdata; tl_d.d_error = perr;
                    tl_d.d_opcode = p_rd ? AccessAckData : AccessAck;
                end
            end else if (!tl_h.d_ready && $urandom_range(0, 5) == 0) begin
                tl_d.d_valid = 1; tl_d.d_data = $urandom; tl_d.d_error = $urandom_range(0, 1);
            end
            if (tl_h.a_valid && ar_hold > 0) begin
                tl_d.a_ready = 0; ar_hold--;
            end else begin
                tl_d.a_ready = rand_ar ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            p_av = tl_h.a_valid; p_ar = tl_d.a_ready; p_rd = (tl_h.a_opcode == Get);
            p_dv = tl_d.d_valid; p_dr = tl_h.d_ready;
        end
    end

    // Result consumer
    initial begin
        rsp_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid_o && rr_hold > 0) begin
                rsp_ready_i = 1'b0; rr_hold--;
            end else begin
                rsp_ready_i = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    task automatic run_txn(input logic [31:0] key, input logic [31:0] rd_data,
                           input bit wr_err, input bit drop_wr, input bit rd_err,
                           input bit drop_rd, input int dly, input bit wait_done);
        cfg_t c;
        int a0, d0;
        bit ok;
        c.key = key; c.rd_data = rd_data; c.wr_err = wr_err; c.drop_wr = drop_wr;
        c.rd_err = rd_err; c.drop_rd = drop_rd; c.dly = dly;
        cfg_q.push_back(c);
        a0 = n_acc; d0 = n_done;
        @(negedge clk);
        req_valid_i = 1'b1; req_key_i = key;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (n_acc > a0) begin ok = 1; break; end
        end
        req_valid_i = 1'b0;
        if (!ok) chk("req_accept_timeout", 0, 1);
        if (wait_done) begin
            ok = 0;
            for (int i = 0; i < 500; i++) begin
                if (n_done > d0) begin ok = 1; break; end
                @(negedge clk);
            end
            if (!ok) chk("rsp_timeout", 0, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        bit ok;
        rst_ni = 1'b0; req_valid_i = 1'b0; req_key_i = '0;
        repeat (3) @(negedge clk);
        #2 rst_ni = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_req_ready", req_ready_o, 1);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_rsp_fields", {rsp_hit_o, rsp_index_o, rsp_err_o}, 0);
        chk("reset_a_valid", tl_h.a_valid, 0);
        chk("reset_d_ready", tl_h.d_ready, 0);

        run_txn(32'hDEAD_BEEF, 32'h8000_0011, 0, 0, 0, 0, 0, 1);
        chk("beef_hit", last_hit, 1);
        chk("beef_index", last_idx, 17);
        chk("beef_err", last_err, 0);
        chk("beef_latency", last_lat, 5);
        chk("beef_puts_gets", {16'(last_puts), 16'(last_gets)}, {16'd1, 16'd1});

        run_txn(32'h1234_5678, 32'h0000_0000, 0, 0, 0, 0, 1, 1);
        chk("miss_fields", {last_hit, last_idx, last_err}, 0);

        run_txn(32'h0BAD_F00D, 32'h8000_003F, 0, 0, 1, 0, 0, 1);
        chk("rderr_fields", {last_hit, last_idx, last_err}, 8'b0_000000_1);

        run_txn(32'hCAFE_0001, 32'h8000_0005, 1, 0, 0, 0, 0, 1);
        chk("wrerr_fields", {last_hit, last_idx, last_err}, 8'b0_000000_1);
        chk("wrerr_no_get", last_gets, 0);

        run_txn(32'hCAFE_0002, 32'h8000_0005, 0, 1, 0, 0, 0, 1);
        chk("wr_timeout_err", last_err, 1);
        chk("wr_timeout_cycles", last_wr_lat, TO + 1);
        chk("wr_timeout_no_get", last_gets, 0);

        run_txn(32'hCAFE_0003, 32'h8000_0005, 0, 0, 0, 1, 0, 1);
        chk("rd_timeout_fields", {last_hit, last_idx, last_err}, 8'b0_000000_1);

        d0 = n_done;
        ar_hold = 7; rr_hold = 3;
        run_txn(32'h5555_AAAA, 32'h8000_002A, 0, 0, 0, 0, 0, 1);
        repeat (4) @(negedge clk);
        chk("stall_hit_index", {last_hit, last_idx, last_err}, 8'b1_101010_0);
        chk("stall_latency", last_lat, 12);
        chk("stall_single_rsp", n_done - d0, 1);

        run_txn(32'h7777_0000, 32'h8000_0001, 0, 0, 0, 1, 0, 0);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_is_read && m_wait > 0) begin ok = 1; break; end
        end
        chk("reach_rd_rsp", ok, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_a_valid", tl_h.a_valid, 0);
        chk("midrst_d_ready", tl_h.d_ready, 0);
        chk("midrst_rsp_valid", rsp_valid_o, 0);
        @(negedge clk);
        #2 rst_ni = 1'b1;
        run_txn(32'hDEAD_BEEF, 32'h8000_0011, 0, 0, 0, 0, 0, 1);
        chk("post_rst_fields", {last_hit, last_idx, last_err}, 8'b1_010001_0);
        chk("post_rst_latency", last_lat, 5);

        rand_ar = 1; rand_rr = 1;
        for (int t = 0; t < 60; t++) begin
            run_txn($urandom, $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 3), 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
